mips_branch_predictor: RTL and testbench

Parametrised dynamic branch predictor for the pipelined MIPS core. It replaces the current implicit "predict not-taken, resolve in MEM" policy with a direct-mapped branch target buffer (BTB) holding 2-bit saturating counters. The IF stage receives a same-cycle prediction and target. The MEM stage reports each resolved branch, and the block returns a mispredict flag and redirect PC that drive the flush of IF/ID/EX. Two saturating statistics counters support performance measurement.

---
 rtl/mips_bp_pkg.sv | 26 ++
 rtl/bp_sat_ctr.sv | 19 +
 rtl/mips_branch_predictor.sv | 96 +++++++++
 tb/tb_mips_branch_predictor.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bp_pkg.sv
// Shared encodings and the BTB entry layout for the MIPS dynamic branch predictor.
// The tag field is sized for the smallest BTB; unused high tag bits are always zero.
package mips_bp_pkg;

   localparam logic [1:0] CTR_SNT   = 2'b00;
   localparam logic [1:0] CTR_WNT   = 2'b01;
   localparam logic [1:0] CTR_WT    = 2'b10;
   localparam logic [1:0] CTR_ST    = 2'b11;
   localparam logic [1:0] CTR_INIT  = CTR_WNT;
   localparam logic [1:0] CTR_ALLOC = CTR_WT;

   localparam int TAG_MAX_W = 30;

   typedef struct packed {
      logic                 valid;
      logic [TAG_MAX_W-1:0] tag;
      logic [29:0]          target;
      logic [1:0]           ctr;
   } bp_entry_t;

   // Tag is pc[31:idx_w+2], zero-extended into the fixed-width tag field.
   function automatic logic [TAG_MAX_W-1:0] tag_of(input logic [31:0] pc, input int idx_w);
      return TAG_MAX_W'(pc >> (idx_w + 2));
   endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Combinational next state of a 2-bit saturating branch counter.
module bp_sat_ctr
   import mips_bp_pkg::*;
(
   input  logic [1:0] ctr,
   input  logic       taken,
   output logic [1:0] ctr_next
);

   always_comb begin
      ctr_next = ctr;
      if (taken) begin
         if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
      end else begin
         if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
      end
   end

endmodule

// File: rtl/mips_branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: same-cycle prediction for IF,
// resolution/redirect for MEM, and saturating branch/mispredict statistics.
module mips_branch_predictor
   import mips_bp_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int STAT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       if_pc,
   output logic              pred_taken,
   output logic [31:0]       pred_target,
   input  logic              upd_valid,
   input  logic [31:0]       upd_pc,
   input  logic              upd_taken,
   input  logic [31:0]       upd_target,
   input  logic              upd_pred_taken,
   input  logic [31:0]       upd_pred_target,
   output logic              mispredict,
   output logic [31:0]       redirect_pc,
   input  logic              stat_clr,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_mispredicts
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);
   localparam logic [STAT_W-1:0] STAT_MAX = '1;
   localparam bp_entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_INIT};

   // Register array rather than a RAM so the whole table clears on async reset.
   bp_entry_t btb [ENTRIES];

   logic [IDX_W-1:0] if_idx;
   logic [IDX_W-1:0] upd_idx;
   bp_entry_t        if_entry;
   bp_entry_t        upd_entry;
   logic             if_hit;
   logic             upd_hit;
   logic [1:0]       ctr_next;

   assign if_idx    = if_pc[IDX_W+1:2];
   assign upd_idx   = upd_pc[IDX_W+1:2];
   assign if_entry  = btb[if_idx];
   assign upd_entry = btb[upd_idx];
   assign if_hit    = if_entry.valid && (if_entry.tag == tag_of(if_pc, IDX_W));
   assign upd_hit   = upd_entry.valid && (upd_entry.tag == tag_of(upd_pc, IDX_W));

   assign pred_taken  = if_hit && if_entry.ctr[1];
   assign pred_target = pred_taken ? {if_entry.target, 2'b00} : 32'd0;

   bp_sat_ctr u_sat_ctr (
      .ctr      (upd_entry.ctr),
      .taken    (upd_taken),
      .ctr_next (ctr_next)
   );

   // upd_valid is a single-cycle strobe with no backpressure: every asserted
   // cycle is one resolved branch and is always consumed at the next edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ENTRIES; i++) btb[i] <= ENTRY_RST;
      end else if (upd_valid) begin
         if (upd_hit) begin
            btb[upd_idx].ctr <= ctr_next;
            if (upd_taken) btb[upd_idx].target <= upd_target[31:2];
         end else if (upd_taken) begin
            btb[upd_idx] <= '{valid: 1'b1, tag: tag_of(upd_pc, IDX_W),
                              target: upd_target[31:2], ctr: CTR_ALLOC};
         end
      end
   end

   assign mispredict = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
   assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;

   // A clear in the same cycle as an increment wins and drops that event.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else if (stat_clr) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (upd_valid && (stat_branches != STAT_MAX))
            stat_branches <= stat_branches + STAT_ONE;
         if (mispredict && (stat_mispredicts != STAT_MAX))
            stat_mispredicts <= stat_mispredicts + STAT_ONE;
      end
   end

endmodule

// File: tb/tb_mips_branch_predictor.sv
// Directed bench for mips_branch_predictor: vector table for lookup/update/redirect,
// hand-written sequences for statistics saturation, clear and asynchronous reset.
module tb_mips_branch_predictor;

   localparam int ENTRIES = 16;
   localparam int STAT_W  = 4;
   localparam logic [31:0] PC_A = 32'h0040_0010;
   localparam logic [31:0] PC_B = 32'h0040_0050;
   localparam logic [31:0] PC_C = 32'h0040_0020;
   localparam logic [31:0] PC_D = 32'h0040_0030;
   localparam logic [31:0] T1   = 32'h0040_0100;
   localparam logic [31:0] T2   = 32'h0040_0200;
   localparam logic [31:0] T3   = 32'h0040_0300;

   logic              clk = 1'b0;
   logic              reset;
   logic [31:0]       if_pc;
   logic              pred_taken;
   logic [31:0]       pred_target;
   logic              upd_valid;
   logic [31:0]       upd_pc;
   logic              upd_taken;
   logic [31:0]       upd_target;
   logic              upd_pred_taken;
   logic [31:0]       upd_pred_target;
   logic              mispredict;
   logic [31:0]       redirect_pc;
   logic              stat_clr;
   logic [STAT_W-1:0] stat_branches;
   logic [STAT_W-1:0] stat_mispredicts;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_br   = 0;
   int exp_mp   = 0;

   typedef struct {
      logic [31:0] if_pc;
      logic        upd_valid;
      logic [31:0] upd_pc;
      logic        upd_taken;
      logic [31:0] upd_target;
      logic        upd_pred_taken;
      logic [31:0] upd_pred_target;
      logic        exp_pt;
      logic [31:0] exp_ptgt;
      logic        exp_mp;
      logic [31:0] exp_redir;
   } vec_t;

   vec_t vecs [19];

   mips_branch_predictor #(.ENTRIES(ENTRIES), .STAT_W(STAT_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .if_pc            (if_pc),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .upd_pred_taken   (upd_pred_taken),
      .upd_pred_target  (upd_pred_target),
      .mispredict       (mispredict),
      .redirect_pc      (redirect_pc),
      .stat_clr         (stat_clr),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   // clock / reset block
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [31:0] lpc, input logic v, input logic [31:0] pc,
                               input logic tk, input logic [31:0] tg, input logic ptk,
                               input logic [31:0] ptg, input logic ept, input logic [31:0] eptg,
                               input logic emp, input logic [31:0] erd);
      vec_t r;
      r.if_pc = lpc; r.upd_valid = v; r.upd_pc = pc; r.upd_taken = tk; r.upd_target = tg;
      r.upd_pred_taken = ptk; r.upd_pred_target = ptg;
      r.exp_pt = ept; r.exp_ptgt = eptg; r.exp_mp = emp; r.exp_redir = erd;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v >= (1 << STAT_W) - 1) ? v : v + 1;
   endfunction

   // driver tasks
   task automatic drive_upd(input logic v, input logic [31:0] pc, input logic tk,
                            input logic [31:0] tg, input logic ptk, input logic [31:0] ptg);
      upd_valid = v; upd_pc = pc; upd_taken = tk; upd_target = tg;
      upd_pred_taken = ptk; upd_pred_target = ptg;
   endtask

   task automatic pulse(input int n, input logic [31:0] pc, input logic tk, input logic ptk,
                        input logic clr);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         drive_upd(1'b1, pc, tk, T1, ptk, 32'd0);
         stat_clr = clr;
         if (clr) begin
            exp_br = 0;
            exp_mp = 0;
         end else begin
            exp_br = sat_inc(exp_br);
            if (tk != ptk) exp_mp = sat_inc(exp_mp);
         end
      end
      @(negedge clk);
      drive_upd(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      stat_clr = 1'b0;
      #1;
   endtask

   task automatic check_stats(input string tag);
      check({tag, " stat_branches"}, 32'(stat_branches), 32'(exp_br));
      check({tag, " stat_mispredicts"}, 32'(stat_mispredicts), 32'(exp_mp));
   endtask

   initial begin
      //           lookup  v     upd_pc        tk    target  ptk   ptgt  exp_pt exp_ptgt exp_mp exp_redir
      vecs[0]  = mk(PC_A, 1'b1, PC_A,         1'b1, T1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, T1);
      vecs[1]  = mk(PC_A, 1'b0, 32'd0,        1'b0, 32'd0, 1'b0, 32'd0, 1'b1, T1, 1'b0, 32'd4);
      vecs[2]  = mk(PC_A, 1'b1, PC_A,         1'b1, T1, 1'b1, T1, 1'b1, T1, 1'b0, T1);
      vecs[3]  = mk(PC_A, 1'b1, PC_A,         1'b1, T1, 1'b1, T1, 1'b1, T1, 1'b0, T1);
      vecs[4]  = mk(PC_A, 1'b1, PC_A,         1'b1, T1, 1'b1, T1, 1'b1, T1, 1'b0, T1);
      vecs[5]  = mk(PC_A, 1'b1, PC_A,         1'b0, T1, 1'b1, T1, 1'b1, T1, 1'b1, 32'h0040_0014);
      vecs[6]  = mk(PC_A, 1'b0, 32'd0,        1'b0, 32'd0, 1'b0, 32'd0, 1'b1, T1, 1'b0, 32'd4);
      vecs[7]  = mk(PC_A, 1'b1, PC_A,         1'b0, T1, 1'b1, T1, 1'b1, T1, 1'b1, 32'h0040_0014);
      vecs[8]  = mk(PC_A, 1'b0, 32'd0,        1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd4);
      vecs[9]  = mk(PC_A, 1'b1, PC_A,         1'b1, T1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, T1);
      vecs[10] = mk(PC_A, 1'b0, 32'd0,        1'b0, 32'd0, 1'b0, 32'd0, 1'b1, T1, 1'b0, 32'd4);
      vecs[11] = mk(PC_A, 1'b1, PC_A,         1'b1, T2, 1'b1, T1, 1'b1, T1, 1'b1, T2);
      vecs[12] = mk(PC_A, 1'b0, 32'd0,        1'b0, 32'd0, 1'b0, 32'd0, 1'b1, T2, 1'b0, 32'd4);
      vecs[13] = mk(PC_A, 1'b1, PC_B,         1'b1, T3, 1'b0, 32'd0, 1'b1, T2, 1'b1, T3);
      vecs[14] = mk(PC_A, 1'b0, 32'd0,        1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd4);
      vecs[15] = mk(PC_B, 1'b0, 32'd0,        1'b0, 32'd0, 1'b0, 32'd0, 1'b1, T3, 1'b0, 32'd4);
      vecs[16] = mk(PC_C, 1'b1, PC_C,         1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h0040_0024);
      vecs[17] = mk(PC_C, 1'b0, 32'd0,        1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd4);
      vecs[18] = mk(PC_B, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b1, T1, 1'b1, T3, 1'b1, 32'h0000_0000);

      reset = 1'b0;
      stat_clr = 1'b0;
      if_pc = PC_A;
      drive_upd(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      #2;
      check("reset pred_taken", 32'(pred_taken), 32'd0);
      check("reset pred_target", pred_target, 32'd0);
      check_stats("reset");
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         if_pc = vecs[i].if_pc;
         drive_upd(vecs[i].upd_valid, vecs[i].upd_pc, vecs[i].upd_taken, vecs[i].upd_target,
                   vecs[i].upd_pred_taken, vecs[i].upd_pred_target);
         #1;
         check($sformatf("v%0d pred_taken", i), 32'(pred_taken), 32'(vecs[i].exp_pt));
         check($sformatf("v%0d pred_target", i), pred_target, vecs[i].exp_ptgt);
         check($sformatf("v%0d mispredict", i), 32'(mispredict), 32'(vecs[i].exp_mp));
         if (vecs[i].exp_mp)
            check($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].exp_redir);
         else
            check($sformatf("v%0d redirect_known", i), 32'($isunknown(redirect_pc)), 32'd0);
         if (vecs[i].upd_valid) exp_br = sat_inc(exp_br);
         if (vecs[i].exp_mp) exp_mp = sat_inc(exp_mp);
      end
      @(negedge clk);
      drive_upd(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      #1;
      check_stats("after table");

      pulse(20, PC_C, 1'b0, 1'b0, 1'b0);
      check_stats("branch sat");
      pulse(10, PC_D, 1'b1, 1'b0, 1'b0);
      check_stats("mispredict sat");
      pulse(1, PC_D, 1'b1, 1'b0, 1'b1);
      check_stats("clear wins");
      pulse(1, PC_D, 1'b1, 1'b0, 1'b0);
      check_stats("count after clear");

      if_pc = PC_B;
      #1;
      check("pre-reset hit B", 32'(pred_taken), 32'd1);
      drive_upd(1'b1, PC_C, 1'b1, T2, 1'b0, 32'd0);
      #1;
      reset = 1'b0;
      exp_br = 0;
      exp_mp = 0;
      #1;
      check("async reset pred_taken", 32'(pred_taken), 32'd0);
      check("async reset pred_target", pred_target, 32'd0);
      check_stats("async reset");
      @(negedge clk);
      drive_upd(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      if_pc = PC_B;
      #1;
      check("post-reset miss B", 32'(pred_taken), 32'd0);
      if_pc = PC_C;
      #1;
      check("lost in-flight update C", 32'(pred_taken), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
